// File: rtl/serv_uart_mmio_pkg.sv
// Shared register map and bit positions for the serv UART MMIO responder.
package serv_uart_mmio_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;

  localparam int STAT_RX_EMPTY = 0;
  localparam int STAT_RX_FULL  = 1;
  localparam int STAT_TX_EMPTY = 2;
  localparam int STAT_TX_FULL  = 3;
  localparam int STAT_OVERRUN  = 4;
  localparam int STAT_FRAME    = 5;

  localparam int CTRL_TX_EN = 0;
  localparam int CTRL_RX_EN = 1;
  localparam int CTRL_RX_IE = 2;
  localparam int CTRL_TX_IE = 3;

  localparam logic [31:0] EMPTY_READ = 32'h8000_0000;

endpackage

// File: rtl/serv_uart_mmio_sync_fifo.sv
// Small synchronous FIFO; wrap-bit pointers give full/empty, and push+pop is legal even when full.
module sync_fifo
  import serv_uart_mmio_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]                  wr_q, wr_d, rd_q, rd_d;
  logic [DEPTH-1:0][WIDTH-1:0]  mem_q, mem_d;
  logic                         do_push, do_pop;

  assign empty   = (wr_q == rd_q);
  assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  // Head reads as zero while empty so downstream never sees stale data.
  assign dout    = empty ? '0 : mem_q[rd_q[AW-1:0]];

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    if (do_push) begin
      mem_d[wr_q[AW-1:0]] = din;
      wr_d = wr_q + (AW+1)'(1);
    end
    if (do_pop) rd_d = rd_q + (AW+1)'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
    end
  end

endmodule

// File: rtl/serv_uart_mmio.sv
// serv data-bus UART responder: DATA/STATUS/CTRL registers over TX and RX FIFOs.
module serv_uart_mmio
  import serv_uart_mmio_pkg::*;
#(
  parameter int TX_DEPTH = 4,
  parameter int RX_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        bus_cs,
  input  logic        bus_we,
  input  logic [31:0] bus_addr,
  input  logic [31:0] bus_wdata,
  input  logic [3:0]  bus_wmask,
  output logic [31:0] bus_rdata,
  output logic        bus_ack,
  output logic        tx_enable,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        rx_enable,
  output logic        rx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        rx_error,
  output logic        irq
);
  logic        ack_q, ack_d;
  logic [31:0] rdata_q, rdata_d;
  logic [3:0]  ctrl_q, ctrl_d;
  logic        ovr_q, ovr_d, ferr_q, ferr_d, rx_error_q, rx_error_d;
  logic        tx_full, tx_empty, rx_full, rx_empty;
  logic        tx_push, tx_pop, rx_push, rx_pop;
  logic        accept, data_wr, clr_ovr, clr_ferr;
  logic [7:0]  rx_head;
  logic [1:0]  reg_sel;
  logic [31:0] status, rd_val;
  logic        unused_bits;

  assign unused_bits = ^{bus_addr[31:4], bus_addr[1:0], bus_wdata[31:8], bus_wmask[3:1]};

  assign reg_sel = bus_addr[3:2];
  assign data_wr = bus_we & (reg_sel == REG_DATA) & bus_wmask[0];
  assign tx_valid = ctrl_q[CTRL_TX_EN] & ~tx_empty;
  assign tx_pop   = tx_valid & tx_ready;
  // A DATA write into a full TX FIFO waits unless the transmitter frees a slot this cycle.
  assign accept  = bus_cs & ~ack_q & ~(data_wr & tx_full & ~tx_pop);
  assign tx_push = accept & data_wr;
  assign rx_pop  = accept & ~bus_we & (reg_sel == REG_DATA) & ~rx_empty;
  assign rx_push = rx_valid & (~rx_full | rx_pop);
  assign clr_ovr  = accept & bus_we & (reg_sel == REG_STATUS) & bus_wdata[STAT_OVERRUN];
  assign clr_ferr = accept & bus_we & (reg_sel == REG_STATUS) & bus_wdata[STAT_FRAME];

  assign bus_ack   = ack_q;
  assign bus_rdata = rdata_q;
  assign tx_enable = ctrl_q[CTRL_TX_EN];
  assign rx_enable = ctrl_q[CTRL_RX_EN];
  assign rx_ready  = ~rx_full;
  assign irq = (~rx_empty & ctrl_q[CTRL_RX_IE]) | (tx_empty & ctrl_q[CTRL_TX_IE]);

  always_comb begin
    status = '0;
    status[STAT_RX_EMPTY] = rx_empty;
    status[STAT_RX_FULL]  = rx_full;
    status[STAT_TX_EMPTY] = tx_empty;
    status[STAT_TX_FULL]  = tx_full;
    status[STAT_OVERRUN]  = ovr_q;
    status[STAT_FRAME]    = ferr_q;
    case (reg_sel)
      REG_DATA:   rd_val = rx_empty ? EMPTY_READ : {24'b0, rx_head};
      REG_STATUS: rd_val = status;
      REG_CTRL:   rd_val = {28'b0, ctrl_q};
      default:    rd_val = '0;
    endcase

    ack_d      = accept;
    rdata_d    = (accept & ~bus_we) ? rd_val : rdata_q;
    ctrl_d     = (accept & bus_we & (reg_sel == REG_CTRL) & bus_wmask[0]) ? bus_wdata[3:0] : ctrl_q;
    rx_error_d = rx_error;
    // Sets are ORed after the clear so a same-cycle event survives a W1C.
    ovr_d  = (ovr_q & ~clr_ovr) | (rx_valid & rx_full & ~rx_pop);
    ferr_d = (ferr_q & ~clr_ferr) | (rx_error & ~rx_error_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_q      <= 1'b0;
      rdata_q    <= '0;
      ctrl_q     <= '0;
      ovr_q      <= 1'b0;
      ferr_q     <= 1'b0;
      rx_error_q <= 1'b0;
    end else begin
      ack_q      <= ack_d;
      rdata_q    <= rdata_d;
      ctrl_q     <= ctrl_d;
      ovr_q      <= ovr_d;
      ferr_q     <= ferr_d;
      rx_error_q <= rx_error_d;
    end
  end

  sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk(clk), .rst_n(rst_n), .push(tx_push), .pop(tx_pop), .din(bus_wdata[7:0]),
    .dout(tx_data), .full(tx_full), .empty(tx_empty)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk(clk), .rst_n(rst_n), .push(rx_push), .pop(rx_pop), .din(rx_data),
    .dout(rx_head), .full(rx_full), .empty(rx_empty)
  );

endmodule

// File: tb/tb_serv_uart_mmio.sv
// Bench for serv_uart_mmio: queue-based register model checked every cycle plus directed literal checks.
module tb_serv_uart_mmio;
  localparam int TXD = 4;
  localparam int RXD = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        bus_cs = 1'b0, bus_we = 1'b0;
  logic [31:0] bus_addr = '0, bus_wdata = '0;
  logic [3:0]  bus_wmask = '0;
  logic [31:0] bus_rdata;
  logic        bus_ack, tx_enable, tx_valid, rx_enable, rx_ready, irq;
  logic [7:0]  tx_data;
  logic        tx_ready = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0, rx_error = 1'b0;

  serv_uart_mmio #(.TX_DEPTH(TXD), .RX_DEPTH(RXD)) dut (
    .clk(clk), .rst_n(rst_n), .bus_cs(bus_cs), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_wmask(bus_wmask), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
    .tx_enable(tx_enable), .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .rx_enable(rx_enable), .rx_ready(rx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_error(rx_error), .irq(irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;
  bit chk_on = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0]  txq[$];
  logic [7:0]  rxq[$];
  logic [3:0]  m_ctrl;
  logic        m_ovr, m_fe, m_prev_err, m_ack, m_rd_ack;
  logic [31:0] m_rdata;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      txq.delete(); rxq.delete();
      m_ctrl = 0; m_ovr = 0; m_fe = 0; m_prev_err = 0;
      m_ack = 0; m_rd_ack = 0; m_rdata = 0;
    end else begin
      int sel;
      logic tpop, dwr, acc;
      logic [31:0] rv;
      sel  = int'(bus_addr[3:2]);
      tpop = m_ctrl[0] && txq.size() != 0 && tx_ready;
      dwr  = bus_we && sel == 0 && bus_wmask[0];
      acc  = bus_cs && !m_ack && !(dwr && txq.size() == TXD && !tpop);
      case (sel)
        0: rv = (rxq.size() != 0) ? {24'b0, rxq[0]} : 32'h8000_0000;
        1: rv = {26'b0, m_fe, m_ovr, txq.size() == TXD, txq.size() == 0,
                 rxq.size() == RXD, rxq.size() == 0};
        2: rv = {28'b0, m_ctrl};
        default: rv = 0;
      endcase
      if (tpop) void'(txq.pop_front());
      m_rd_ack = acc && !bus_we;
      if (acc && !bus_we) begin
        m_rdata = rv;
        if (sel == 0 && rxq.size() != 0) void'(rxq.pop_front());
      end
      if (acc && bus_we) begin
        if (sel == 0 && bus_wmask[0]) txq.push_back(bus_wdata[7:0]);
        if (sel == 1) begin
          if (bus_wdata[4]) m_ovr = 0;
          if (bus_wdata[5]) m_fe = 0;
        end
        if (sel == 2 && bus_wmask[0]) m_ctrl = bus_wdata[3:0];
      end
      if (rx_valid) begin
        if (rxq.size() < RXD) rxq.push_back(rx_data);
        else m_ovr = 1;
      end
      if (rx_error && !m_prev_err) m_fe = 1;
      m_prev_err = rx_error;
      m_ack = acc;
    end
  end

  // ---------------- per-cycle compare ----------------
  logic [7:0] txlog[$];
  always @(negedge clk) begin
    if (chk_on) begin
      chk("ack", {31'b0, bus_ack}, {31'b0, m_ack});
      chk("tx_enable", {31'b0, tx_enable}, {31'b0, m_ctrl[0]});
      chk("rx_enable", {31'b0, rx_enable}, {31'b0, m_ctrl[1]});
      chk("tx_valid", {31'b0, tx_valid}, {31'b0, m_ctrl[0] && txq.size() != 0});
      chk("tx_data", {24'b0, tx_data}, {24'b0, (txq.size() != 0) ? txq[0] : 8'h00});
      chk("rx_ready", {31'b0, rx_ready}, {31'b0, rxq.size() < RXD});
      chk("irq", {31'b0, irq},
          {31'b0, (rxq.size() != 0 && m_ctrl[2]) || (txq.size() == 0 && m_ctrl[3])});
      if (m_rd_ack) chk("rdata", bus_rdata, m_rdata);
      if (tx_valid && tx_ready) txlog.push_back(tx_data);
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
  endtask

  task automatic bus(input logic we, input logic [1:0] a, input logic [31:0] d,
                     input logic [3:0] m, output logic [31:0] rd);
    logic ok;
    logic [31:0] ad;
    ad = $urandom();
    ad[3:2] = a;
    bus_cs = 1; bus_we = we; bus_addr = ad; bus_wdata = d; bus_wmask = m;
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(posedge clk); #1;
      if (bus_ack) ok = 1;
    end
    rd = bus_rdata;
    bus_cs = 0;
    chk("bus_timeout", {31'b0, ok}, 32'd1);
    cyc(1);
  endtask

  task automatic rx_inject(input logic [7:0] b);
    rx_data = b; rx_valid = 1;
    cyc(1);
    rx_valid = 0;
  endtask

  initial begin
    logic [31:0] rd;
    logic [7:0]  exp_bytes[$];
    cyc(3);
    rst_n = 1;
    chk_on = 1;
    chk("reset_rdata", bus_rdata, 32'h0);
    chk("reset_rx_ready", {31'b0, rx_ready}, 32'd1);
    chk("reset_tx_data", {24'b0, tx_data}, 32'h0);
    bus(0, 2'd1, 0, 4'h0, rd); chk("reset_status", rd, 32'h0000_0005);
    bus(0, 2'd2, 0, 4'h0, rd); chk("reset_ctrl", rd, 32'h0);

    // basic transmit
    bus(1, 2'd2, 32'h1, 4'h1, rd);
    bus(1, 2'd0, 32'h41, 4'h1, rd);
    bus(1, 2'd0, 32'h42, 4'h1, rd);
    chk("tx_head0", {24'b0, tx_data}, 32'h41);
    tx_ready = 1; cyc(1); tx_ready = 0;
    chk("tx_head1", {24'b0, tx_data}, 32'h42);
    tx_ready = 1; cyc(1); tx_ready = 0;
    bus(0, 2'd1, 0, 4'h0, rd); chk("tx_drained", rd & 32'h4, 32'h4);

    // stall on full TX FIFO
    txlog.delete();
    for (int i = 0; i < 4; i++) bus(1, 2'd0, 32'h50 + i, 4'h1, rd);
    bus_cs = 1; bus_we = 1; bus_addr = 32'h0; bus_wdata = 32'h54; bus_wmask = 4'h1;
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      chk("stall_ack", {31'b0, bus_ack}, 32'd0);
    end
    tx_ready = 1; cyc(1); tx_ready = 0;
    chk("stall_release", {31'b0, bus_ack}, 32'd1);
    bus_cs = 0;
    cyc(1);
    tx_ready = 1; cyc(8); tx_ready = 0;
    exp_bytes = '{8'h50, 8'h51, 8'h52, 8'h53, 8'h54};
    chk("tx_count", txlog.size(), 32'd5);
    for (int i = 0; i < 5 && i < txlog.size(); i++)
      chk("tx_order", {24'b0, txlog[i]}, {24'b0, exp_bytes[i]});

    // RX fill and overrun
    for (int i = 0; i < 4; i++) rx_inject(8'h10 + 8'(i));
    chk("rx_ready_full", {31'b0, rx_ready}, 32'd0);
    rx_inject(8'h14);
    bus(0, 2'd1, 0, 4'h0, rd); chk("status_overrun", rd, 32'h0000_0016);
    for (int i = 0; i < 4; i++) begin
      bus(0, 2'd0, 0, 4'h0, rd); chk("rx_byte", rd, 32'h10 + i);
    end
    bus(0, 2'd0, 0, 4'h0, rd); chk("rx_empty_read", rd, 32'h8000_0000);

    // frame error and W1C
    rx_error = 1; cyc(2); rx_error = 0; cyc(1);
    bus(0, 2'd1, 0, 4'h0, rd); chk("status_sticky", rd, 32'h0000_0035);
    bus(1, 2'd1, 32'h30, 4'h1, rd);
    bus(0, 2'd1, 0, 4'h0, rd); chk("status_cleared", rd, 32'h0000_0005);

    // overrun set wins over same-cycle clear
    for (int i = 0; i < 4; i++) rx_inject(8'h20 + 8'(i));
    bus_cs = 1; bus_we = 1; bus_addr = 32'h4; bus_wdata = 32'h10; bus_wmask = 4'h1;
    rx_data = 8'h99; rx_valid = 1;
    cyc(1);
    rx_valid = 0; bus_cs = 0;
    chk("w1c_ack", {31'b0, bus_ack}, 32'd1);
    cyc(1);
    bus(0, 2'd1, 0, 4'h0, rd); chk("set_wins", rd, 32'h0000_0016);
    for (int i = 0; i < 4; i++) bus(0, 2'd0, 0, 4'h0, rd);

    // randomized traffic
    bus(1, 2'd2, 32'h1, 4'h1, rd);
    for (int it = 0; it < 400; it++) begin
      logic we;
      logic [1:0] a;
      logic [31:0] d;
      tx_ready = 1'($urandom_range(0, 1));
      rx_valid = ($urandom_range(0, 3) == 0);
      rx_data  = 8'($urandom());
      rx_error = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 1) == 1) begin
        we = 1'($urandom_range(0, 1));
        a  = 2'($urandom_range(0, 3));
        d  = $urandom();
        if (we && a == 2'd2) d[0] = 1'b1;
        bus(we, a, d, 4'($urandom()), rd);
      end else cyc(1);
    end
    tx_ready = 0; rx_valid = 0; rx_error = 0;
    cyc(2);

    // async reset during a pending read
    bus(1, 2'd2, 32'hF, 4'h1, rd);
    bus(1, 2'd0, 32'h77, 4'h1, rd);
    rx_inject(8'h66);
    cyc(1);
    bus_cs = 1; bus_we = 0; bus_addr = 32'h0; bus_wmask = 4'h0;
    @(posedge clk); #2;
    chk("pre_reset_ack", {31'b0, bus_ack}, 32'd1);
    #1 rst_n = 0;
    #1;
    chk("rst_ack", {31'b0, bus_ack}, 32'd0);
    chk("rst_tx_valid", {31'b0, tx_valid}, 32'd0);
    chk("rst_irq", {31'b0, irq}, 32'd0);
    bus_cs = 0;
    @(posedge clk); #1;
    rst_n = 1;
    cyc(1);
    bus(0, 2'd1, 0, 4'h0, rd); chk("post_reset_status", rd, 32'h0000_0005);
    bus(0, 2'd0, 0, 4'h0, rd); chk("post_reset_data", rd, 32'h8000_0000);

    chk_on = 0;
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
